imem_boot_controller: RTL and testbench

Sequences and shares the instruction memory between a host program-load stream and the CPU fetch port. After reset it holds the CPU stalled, accepts program words over a valid/ready stream, and writes them to consecutive word addresses. It then releases the CPU and routes the CPU fetch address to the memory. It sits between the host/loader interface, the `InstructionMemory` port and the CPU fetch stage.

---
 rtl/imem_ctrl_pkg.sv | 7 +
 rtl/imem_boot_controller.sv | 74 +++++++
 tb/tb_imem_boot_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared states and constants for the instruction-memory boot controller
package imem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam int IMEM_WORDS = 4096;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int BYTE_SHIFT = 2;
endpackage

// File: rtl/imem_boot_controller.sv
// imem_boot_controller: shares instruction memory between a host program-load stream and the CPU fetch port
//   load_*   : valid/ready program stream written to consecutive words from address 0
//   cpu_*    : fetch address in, instruction out, stall held until the image is in place
//   mem_*    : single memory port, write strobe only during accepted load beats
//   word_count / load_done / load_error : status of the current or most recent load
module imem_boot_controller
  import imem_ctrl_pkg::*;
#(
  parameter int WORDS = IMEM_WORDS,
  parameter int CW = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          boot_run,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   cpu_address,
  output logic [31:0]   cpu_read_data,
  output logic          cpu_stall,
  output logic [31:0]   mem_address,
  output logic          mem_write_enable,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data,
  output logic [CW-1:0] word_count,
  output logic          load_done,
  output logic          load_error
);
  state_t r_state, w_next;
  logic [CW-1:0] r_word_count;
  logic r_load_done, r_load_error;
  logic w_accept, w_full, w_run;
  assign w_run = r_state == RUN;
  // load_start in LOAD restarts, so the beat of that cycle must not land
  assign load_ready = r_state == LOAD && !load_start;
  assign w_accept = load_ready && load_valid;
  assign w_full = r_word_count == CW'(WORDS - 1);
  always_comb begin
    w_next = load_start ? LOAD :
             (r_state == IDLE && boot_run) ? RUN :
             (w_accept && load_last) ? RUN :
             (w_accept && w_full) ? IDLE : r_state;
  end
  assign mem_write_enable = w_accept;
  assign mem_write_data = w_accept ? load_data : '0;
  assign mem_address = w_run ? cpu_address :
                       w_accept ? (32'(r_word_count) << BYTE_SHIFT) : '0;
  assign cpu_stall = !w_run;
  assign cpu_read_data = w_run ? mem_read_data : NOP_WORD;
  assign word_count = r_word_count;
  assign load_done = r_load_done;
  assign load_error = r_load_error;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_word_count <= '0;
      r_load_done <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (load_start) begin
        r_word_count <= '0;
        r_load_done <= 1'b0;
        r_load_error <= 1'b0;
      end else if (w_accept) begin
        r_word_count <= r_word_count + 1'b1;
        if (load_last) r_load_done <= 1'b1;
        else if (w_full) r_load_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_controller.sv
// tb_imem_boot_controller: table vectors, directed corner sequences and random traffic against a reference model
module tb_imem_boot_controller;
  localparam int W = 4096;
  logic clk = 1'b0;
  logic reset;
  logic load_start, boot_run, load_valid, load_last;
  logic [31:0] load_data, cpu_address, cpu_read_data, mem_address, mem_write_data, mem_read_data;
  logic load_ready, cpu_stall, mem_write_enable, load_done, load_error;
  logic [12:0] word_count;
  logic [31:0] mem [W];
  logic [31:0] gold [W];
  int errors = 0;
  int checks = 0;
  bit m_load, m_run, m_done, m_err;
  int m_cnt;
  typedef struct {
    logic st, bt, v, last;
    logic [31:0] d, ca;
    logic rdy, we;
    logic [31:0] addr;
    logic stall;
    logic [31:0] rd;
    logic [12:0] wc;
    logic done;
  } vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  imem_boot_controller dut (
    .clk(clk), .reset(reset), .load_start(load_start), .boot_run(boot_run),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .cpu_address(cpu_address), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .word_count(word_count), .load_done(load_done), .load_error(load_error)
  );
  always @(posedge clk) if (mem_write_enable) mem[mem_address[13:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[13:2]];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle_in();
    load_start = 0; boot_run = 0; load_valid = 0; load_last = 0; load_data = '0; cpu_address = '0;
  endtask
  task automatic m_reset();
    m_load = 0; m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;
  endtask
  task automatic mcheck();
    bit acc;
    acc = m_load && load_valid && !load_start;
    chk("ready", load_ready, 32'(m_load && !load_start));
    chk("we", mem_write_enable, 32'(acc));
    chk("addr", mem_address, m_run ? cpu_address : acc ? 32'(m_cnt * 4) : 32'h0);
    chk("wdata", mem_write_data, acc ? load_data : 32'h0);
    chk("stall", cpu_stall, 32'(!m_run));
    chk("rdata", cpu_read_data, m_run ? gold[cpu_address[13:2]] : 32'h0);
    chk("wc", word_count, 32'(m_cnt));
    chk("done", load_done, 32'(m_done));
    chk("err", load_error, 32'(m_err));
  endtask
  task automatic m_step();
    bit acc;
    acc = m_load && load_valid && !load_start;
    if (load_start) begin
      m_load = 1; m_run = 0; m_cnt = 0; m_done = 0; m_err = 0;
    end else if (acc) begin
      gold[m_cnt] = load_data;
      m_cnt++;
      if (load_last) begin
        m_load = 0; m_run = 1; m_done = 1;
      end else if (m_cnt == W) begin
        m_load = 0; m_err = 1;
      end
    end else if (!m_load && !m_run && boot_run) m_run = 1;
  endtask
  task automatic cycle();
    @(negedge clk);
    mcheck();
    @(posedge clk);
    m_step();
    #1;
  endtask
  initial begin
    for (int i = 0; i < W; i++) begin
      mem[i] = '0;
      gold[i] = '0;
    end
    idle_in();
    m_reset();
    reset = 1;
    #12;
    chk("rst_stall", cpu_stall, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_rdata", cpu_read_data, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    tv[0] = '{1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 13'd0, 0};
    tv[1] = '{0, 0, 1, 0, 32'hE3A00001, 32'h0, 1, 1, 32'h0, 1, 32'h0, 13'd1, 0};
    tv[2] = '{0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 0, 32'h0, 1, 32'h0, 13'd1, 0};
    tv[3] = '{0, 0, 1, 0, 32'hE2800001, 32'h0, 1, 1, 32'h4, 1, 32'h0, 13'd2, 0};
    tv[4] = '{0, 0, 1, 1, 32'hEAFFFFFE, 32'h0, 1, 1, 32'h8, 1, 32'h0, 13'd3, 1};
    tv[5] = '{0, 0, 0, 0, 32'h0, 32'h4, 0, 0, 32'h4, 0, 32'hE2800001, 13'd3, 1};
    tv[6] = '{0, 0, 1, 0, 32'h11111111, 32'h8, 0, 0, 32'h8, 0, 32'hEAFFFFFE, 13'd3, 1};
    for (int i = 0; i < 7; i++) begin
      load_start = tv[i].st; boot_run = tv[i].bt; load_valid = tv[i].v; load_last = tv[i].last;
      load_data = tv[i].d; cpu_address = tv[i].ca;
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i), load_ready, tv[i].rdy);
      chk($sformatf("tv%0d_we", i), mem_write_enable, tv[i].we);
      chk($sformatf("tv%0d_addr", i), mem_address, tv[i].addr);
      chk($sformatf("tv%0d_wdata", i), mem_write_data, tv[i].we ? tv[i].d : 32'h0);
      chk($sformatf("tv%0d_stall", i), cpu_stall, tv[i].stall);
      chk($sformatf("tv%0d_rdata", i), cpu_read_data, tv[i].rd);
      @(posedge clk);
      m_step();
      #1;
      chk($sformatf("tv%0d_wc", i), word_count, tv[i].wc);
      chk($sformatf("tv%0d_done", i), load_done, tv[i].done);
    end
    idle_in();
    cpu_address = 32'h4;
    load_start = 1;
    cycle();
    load_start = 0;
    chk("reload_stall", cpu_stall, 1);
    chk("reload_done", load_done, 0);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = $urandom;
      cycle();
    end
    chk("five_wc", word_count, 5);
    load_start = 1; load_data = 32'hBAD0BAD0;
    cycle();
    load_start = 0;
    chk("restart_wc", word_count, 0);
    load_data = 32'h12345678;
    @(negedge clk);
    chk("restart_addr", mem_address, 0);
    chk("restart_we", mem_write_enable, 1);
    mcheck();
    @(posedge clk);
    m_step();
    #1;
    load_data = 32'h9ABCDEF0;
    cycle();
    load_data = 32'h55AA55AA;
    #2;
    reset = 1;
    #1;
    m_reset();
    chk("areset_stall", cpu_stall, 1);
    chk("areset_ready", load_ready, 0);
    chk("areset_we", mem_write_enable, 0);
    chk("areset_addr", mem_address, 0);
    chk("areset_wc", word_count, 0);
    @(negedge clk);
    reset = 0;
    idle_in();
    @(posedge clk);
    #1;
    boot_run = 1;
    cycle();
    boot_run = 0;
    cpu_address = 32'h4;
    @(negedge clk);
    chk("boot_rd1", cpu_read_data, 32'h9ABCDEF0);
    cpu_address = 32'h0;
    #1;
    chk("boot_rd0", cpu_read_data, 32'h12345678);
    cycle();
    load_start = 1;
    cycle();
    load_start = 0;
    load_valid = 1;
    for (int i = 0; i < W; i++) begin
      load_data = $urandom;
      cycle();
    end
    chk("ovf_err", load_error, 1);
    chk("ovf_wc", word_count, W);
    chk("ovf_stall", cpu_stall, 1);
    chk("ovf_done", load_done, 0);
    @(negedge clk);
    chk("ovf_ready", load_ready, 0);
    chk("ovf_we", mem_write_enable, 0);
    mcheck();
    @(posedge clk);
    m_step();
    #1;
    for (int i = 0; i < 3000; i++) begin
      load_start = ($urandom_range(0, 63) == 0);
      boot_run = ($urandom_range(0, 7) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_last = ($urandom_range(0, 15) == 0);
      load_data = $urandom;
      cpu_address = $urandom_range(0, 63) << 2;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
